// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous block RAM.
// One request is accepted at a time. The RAM is driven for exactly one cycle.
// Read data returns to the owning port with a one-cycle valid pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Port 0: CPU load/store
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // Port 1: display/peripheral fetch
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // RAM side
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e state_q, state_d;

  logic              we_q, we_d;           // latched direction of the accepted request
  logic              port_q, port_d;       // owner of the accepted request
  logic              last_grant_q, last_grant_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;

  logic              sel_valid;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the requesting port; on contention the port that did not win last time.
  always_comb begin
    sel_valid = req0 | req1;
    sel_port  = (req0 && req1) ? ~last_grant_q : req1;
    sel_we    = sel_port ? we1    : we0;
    sel_addr  = sel_port ? addr1  : addr0;
    sel_wdata = sel_port ? wdata1 : wdata0;
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      port_q         <= 1'b0;
      last_grant_q   <= 1'b1;  // port 0 wins the first contention
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      port_q         <= port_d;
      last_grant_q   <= last_grant_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
    end
  end

  // Next-state: writes finish after ISSUE, reads take an extra CAPTURE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (sel_valid) state_d = StIssue;
      StIssue:   state_d = we_q ? StIdle : StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and latched request fields.
  always_comb begin
    we_d           = we_q;
    port_d         = port_q;
    last_grant_d   = last_grant_q;
    gnt0_d         = 1'b0;
    gnt1_d         = 1'b0;
    rvalid0_d      = 1'b0;
    rvalid1_d      = 1'b0;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    mem_wr_en_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          // Bus values for ISSUE are loaded here so they appear with the grant.
          we_d           = sel_we;
          port_d         = sel_port;
          last_grant_d   = sel_port;
          gnt0_d         = ~sel_port;
          gnt1_d         = sel_port;
          mem_wr_en_d    = sel_we;
          mem_addr_d     = sel_addr;
          mem_data_out_d = sel_we ? sel_wdata : '0;
        end
      end
      StIssue: begin
        // Address stays put so the RAM output is stable through CAPTURE.
      end
      StCapture: begin
        if (port_q) begin
          rdata1_d  = mem_data_in;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_data_in;
          rvalid0_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 1K x 16 synchronous RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
  logic [DW-1:0] rdata0, rdata1, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;

  logic [DW-1:0] ram [1024];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [DW-1:0] last_rd [2];

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [9];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .gnt0         (gnt0),
    .rvalid0      (rvalid0),
    .rdata0       (rdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt1         (gnt1),
    .rvalid1      (rvalid1),
    .rdata1       (rdata1),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on wr_en, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_data_out;
    mem_data_in <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance to the falling edge, then score any returned read data.
  task automatic cyc();
    logic [DW-1:0] e;
    @(negedge clk);
    if (rvalid0) begin
      if (exp_q0.size() == 0) begin
        chk("sb_rvalid0_unexpected", {15'h0, rvalid0}, 32'h0);
      end else begin
        e = exp_q0.pop_front();
        chk("sb_rdata0", rdata0, e);
      end
    end
    if (rvalid1) begin
      if (exp_q1.size() == 0) begin
        chk("sb_rvalid1_unexpected", {15'h0, rvalid1}, 32'h0);
      end else begin
        e = exp_q1.pop_front();
        chk("sb_rdata1", rdata1, e);
      end
    end
    if (gnt0 && gnt1) chk("double_grant", {gnt0, gnt1}, 2'b10);
  endtask

  task automatic wait_gnt(input bit port, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 16) begin
      cyc();
      n++;
      got = port ? gnt1 : gnt0;
    end
    chk(port ? "gnt1_seen" : "gnt0_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // Single request from an idle arbiter; returns once the arbiter is idle again.
  task automatic do_req(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
    int n;
    if (!we) begin
      if (port) exp_q1.push_back(exp);
      else      exp_q0.push_back(exp);
    end
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    wait_gnt(port, n);
    chk("gnt_latency", n, 1);
    chk("issue_bus", {mem_wr_en, mem_addr, mem_data_out},
        {we, addr, (we ? wdata : 16'h0)});
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    cyc();
    chk("wr_en_one_cycle", {31'h0, mem_wr_en}, 32'h0);
    if (!we) begin
      cyc();
      chk("rvalid_latency", {31'h0, (port ? rvalid1 : rvalid0)}, 32'h1);
      chk("other_rdata_kept", (port ? rdata0 : rdata1), last_rd[~port]);
      last_rd[port] = exp;
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 10'h000, wdata: 16'h0000, exp: 16'h0010};
    vecs[1] = '{port: 1'b0, we: 1'b1, addr: 10'h000, wdata: 16'h0013, exp: 16'h0000};
    vecs[2] = '{port: 1'b0, we: 1'b0, addr: 10'h000, wdata: 16'h0000, exp: 16'h0013};
    vecs[3] = '{port: 1'b1, we: 1'b1, addr: 10'h3FF, wdata: 16'hFFFF, exp: 16'h0000};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 10'h3FF, wdata: 16'h1234, exp: 16'hFFFF};
    vecs[5] = '{port: 1'b0, we: 1'b0, addr: 10'h07A, wdata: 16'h0000, exp: 16'hBEEF};
    vecs[6] = '{port: 1'b1, we: 1'b1, addr: 10'h155, wdata: 16'hA5A5, exp: 16'h0000};
    vecs[7] = '{port: 1'b0, we: 1'b0, addr: 10'h155, wdata: 16'h0000, exp: 16'hA5A5};
    vecs[8] = '{port: 1'b1, we: 1'b0, addr: 10'h000, wdata: 16'h0000, exp: 16'h0013};

    // Reset state
    do_reset();
    chk("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1}, 4'h0);
    chk("rst_rdata", {rdata0, rdata1}, 32'h0);
    chk("rst_mem", {mem_wr_en, mem_addr, mem_data_out}, 27'h0);

    // Write 0x3FF then read it back with exact cycle timing
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3FF; wdata0 = 16'h03FF;
    cyc();
    chk("w3ff_issue", {gnt0, gnt1, mem_wr_en, mem_addr, mem_data_out},
        {3'b101, 10'h3FF, 16'h03FF});
    req0 = 1'b0;
    cyc();
    chk("w3ff_done", {gnt0, mem_wr_en}, 2'b00);
    req0 = 1'b1; we0 = 1'b0;
    exp_q0.push_back(16'h03FF);
    cyc();
    chk("r3ff_gnt", {gnt0, mem_wr_en, mem_addr}, {2'b10, 10'h3FF});
    req0 = 1'b0;
    cyc();
    chk("r3ff_capture", {rvalid0, mem_wr_en}, 2'b00);
    cyc();
    chk("r3ff_rvalid", {rvalid0, rvalid1}, 2'b10);

    // Preload for the contention tests
    do_req(1'b0, 1'b1, 10'h000, 16'h0010, 16'h0);
    do_req(1'b1, 1'b1, 10'h07A, 16'hBEEF, 16'h0);

    // Simultaneous reads after reset: port 0 first, port 1 in the next idle
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h07A;
    exp_q0.push_back(16'h0010);
    exp_q1.push_back(16'hBEEF);
    cyc();
    chk("both_rd_first", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    wait_gnt(1'b1, n);
    chk("both_rd_gap", n, 3);
    req1 = 1'b0;
    cyc();
    cyc();
    chk("both_rd_rvalid1", {rvalid0, rvalid1}, 2'b01);

    // Both ports hold write requests: grants alternate, wr_en every 2nd cycle
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h100; wdata0 = 16'hAAAA;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h101; wdata1 = 16'h5555;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("alt_cyc%0d", i), {gnt0, gnt1, mem_wr_en},
          {(i == 0 || i == 4), (i == 2 || i == 6), (i % 2 == 0)});
      if (i % 4 == 0) chk("alt_addr0", mem_addr, 10'h100);
      if (i % 4 == 2) chk("alt_addr1", {mem_addr, mem_data_out}, {10'h101, 16'h5555});
      if (i == 6) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // Port 1 alone four times, then contention: port 0 wins
    do_req(1'b0, 1'b1, 10'h200, 16'h0200, 16'h0);
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b1, 10'(12'h201 + i), 16'(16'h0C00 + i), 16'h0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h210; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h211; wdata1 = 16'h2222;
    cyc();
    chk("fair_first", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    wait_gnt(1'b1, n);
    chk("fair_gap", n, 2);
    req1 = 1'b0;
    cyc();

    // Table: read-modify-write and independent per-port data
    for (int i = 0; i < 9; i++)
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Reset during ISSUE of a read: read is dropped, rdata cleared
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
    cyc();
    chk("rst_mid_gnt", {gnt0, mem_wr_en}, 2'b10);
    reset = 1'b1;
    req0 = 1'b0;
    cyc();
    chk("rst_mid_out", {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en}, 5'h0);
    chk("rst_mid_rdata", {rdata0, rdata1}, 32'h0);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_mid_quiet", {rvalid0, rvalid1, mem_wr_en}, 3'h0);
    end
    do_req(1'b0, 1'b0, 10'h3FF, 16'h0, 16'hFFFF);

    chk("sb_q0_empty", exp_q0.size(), 0);
    chk("sb_q1_empty", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
